// File: rtl/uart_cmd_loader.sv
// Frame loader between the UART byte receiver and the NAND sequencer: SYNC + payload, held until release.
// Define UART_CMD_CHECKSUM_EN to add a trailing XOR checksum byte and the CHECK state.
module uart_cmd_loader #(
  parameter int         CMD_SIZE    = 7,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic [11:0] ram_addr_i,
  input  logic        ram_re_i,
  output logic [7:0]  ram_out_o,
  output logic        ready_o,
  input  logic        release_i,
  output logic        frame_err_o,
  output logic        overrun_o
);

  localparam int IDX_W  = $clog2(CMD_SIZE + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int BUF_AW = (CMD_SIZE > 1) ? $clog2(CMD_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CMD_SIZE - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [11:0]      ADDR_LIMIT = 12'(CMD_SIZE);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [1:0] CHECK = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       ram_out_q;
  logic             buf_we;
  logic             timeout;
  logic [7:0]       buf_q [CMD_SIZE];
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  assign timeout = (timer_q == TMR_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    buf_we      = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
          state_d = LOAD;
          idx_d   = '0;
          timer_d = '0;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      LOAD: begin
        // An arriving byte always beats a timeout expiring in the same cycle.
        if (rx_valid_i) begin
          buf_we  = 1'b1;
          idx_d   = idx_q + 1'b1;
          timer_d = '0;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data_i;
          if (idx_q == LAST_IDX) state_d = CHECK;
`else
          if (idx_q == LAST_IDX) state_d = HOLD;
`endif
        end else if (timeout) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      CHECK: begin
        if (rx_valid_i) begin
          timer_d = '0;
          if (rx_data_i == csum_q) begin
            state_d = HOLD;
          end else begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end
        end else if (timeout) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      HOLD: begin
        // A byte coinciding with release is simply dropped, never flagged.
        if (release_i) begin
          state_d   = IDLE;
          overrun_d = 1'b0;
        end else if (rx_valid_i) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      ram_out_q   <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
      if (ram_re_i) begin
        ram_out_q <= (ram_addr_i < ADDR_LIMIT) ? buf_q[ram_addr_i[BUF_AW-1:0]] : 8'h00;
      end
    end
  end

  // Payload storage carries no reset; only the control state is cleared.
  always_ff @(posedge clk_i) begin
    if (rst_ni && buf_we) begin
      buf_q[idx_q[BUF_AW-1:0]] <= rx_data_i;
    end
  end

  assign ram_out_o   = ram_out_q;
  assign ready_o     = (state_q == HOLD);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: doc/uart_cmd_loader.md
Name: uart_cmd_loader

Overview:
- Sits between the UART byte receiver and the NAND command sequencer.
- Collects a framed command from the serial byte stream and stores the payload in an internal byte buffer.
- Once a complete, valid frame is held, raises `ready`. The sequencer then reads the payload out over a RAM-style read port.
- Holds the frame stable until the sequencer releases it, then re-arms for the next frame.

Parameters:
- CMD_SIZE, 7, payload bytes per frame; buffer holds exactly CMD_SIZE bytes.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 50000, maximum clk cycles allowed between consecutive bytes inside a frame.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- rx_data  in  8  received byte from UART.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- ram_addr  in  12  read address from sequencer.
- ram_re  in  1  read enable from sequencer.
- ram_out  out  8  registered read data.
- ready  out  1  valid frame held; level signal.
- release  in  1  sequencer done; frees the buffer.
- frame_err  out  1  one-cycle pulse on checksum failure or timeout.
- overrun  out  1  sticky; a byte arrived while in HOLD.

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to IDLE.
  - ready=0, frame_err=0, overrun=0, ram_out=8'h00.
  - Write index, timeout counter and checksum accumulator cleared.
  - Buffer contents are undefined (not cleared).
- Reset mid-frame or during HOLD aborts the frame: ready drops on the next edge, partial data is discarded, and no frame_err pulse is generated.
- States:
  - IDLE:
    - rx_valid with rx_data==SYNC_BYTE -> LOAD; idx=0, csum=0, timer=0.
    - Any other byte is ignored.
  - LOAD:
    - On rx_valid: buf[idx]<=rx_data, csum<=csum^rx_data, idx<=idx+1, timer<=0.
    - A SYNC_BYTE value received here is treated as data.
    - After the byte written at idx==CMD_SIZE-1, go to CHECK.
    - Without rx_valid, timer increments. At timer==TIMEOUT_CYC-1 -> IDLE and frame_err pulses 1 cycle.
  - CHECK:
    - Waits for the checksum byte; same timeout rule as LOAD.
    - On rx_valid: if rx_data==csum -> HOLD, else -> IDLE with a frame_err pulse.
  - HOLD:
    - ready=1, asserted in the cycle after entry and held.
    - rx_valid is dropped (buffer not written) and overrun is set to 1. overrun clears only on reset or on leaving HOLD via release.
    - release=1 -> IDLE; ready=0 from the next cycle.
    - release while not in HOLD is ignored.
- Read port:
  - If ram_re=1 at a posedge: ram_out <= buf[ram_addr] when ram_addr<CMD_SIZE, else 8'h00. One-cycle latency.
  - If ram_re=0, ram_out holds its value.
  - Reads are legal in any state. Buffer contents are guaranteed stable only in HOLD.
- Simultaneous events:
  - rx_valid and timeout expiry in the same cycle: rx_valid wins, byte is accepted, timer cleared.
  - release and rx_valid in the same HOLD cycle: the byte is dropped and overrun is not set. It is not treated as a SYNC candidate.
- Widths:
  - idx sized $clog2(CMD_SIZE+1).
  - timer sized $clog2(TIMEOUT_CYC+1); no wrap is possible because it is cleared at expiry.

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- Defined: CHECK state present; each frame is SYNC + CMD_SIZE payload + 1 XOR checksum byte.
- Undefined:
  - CHECK state and csum logic are removed.
  - LOAD goes directly to HOLD after the last payload byte.
  - frame_err pulses only on timeout.

Test Plan:
- Good frame (checksum enabled): A5, 01 02 03 04 05 06 07, 00 (XOR of 01..07 = 00) -> ready rises 1 cycle after the checksum byte. Reads at addr 0..6 return 01..07 one cycle after ram_re; addr 7 and addr 12'hFFF return 00.
- Bad checksum: A5, 7 payload bytes 11, then 00 (expected 11) -> frame_err pulses exactly 1 cycle, ready stays 0, state returns to IDLE. A subsequent valid frame is accepted.
- Timeout: A5, 3 payload bytes, then 50000 idle cycles -> frame_err pulses at cycle 50000 after the last byte. A fresh A5 then restarts the frame with idx=0.
- Leading noise and embedded sync: 00 FF A5, then payload A5 A5 A5 A5 A5 A5 A5 and checksum A5 -> garbage ignored, all payload bytes stored as A5, ready asserted.
- Hold/overrun/release: in HOLD, send 3C -> buffer unchanged, overrun=1. Pulse release -> ready=0 and overrun=0 next cycle. Second frame loads normally.
- Reset mid-LOAD: drive rst=0 for 1 cycle after 4 payload bytes -> ready=0, frame_err stays 0, ram_out=00. The next full frame is accepted.
